hps_instr_receiver: RTL

//  FPGA-side end of the HPS instruction path. Captures one 64-bit instruction
//  {data_b,data_a} per rising edge of the HPS wrreg strobe into an instruction

---
 rtl/hps_instr_receiver_if.sv | 33 +++
 rtl/hps_instr_receiver.sv | 101 ++++++++++
 2 files changed

// File: rtl/hps_instr_receiver_if.sv
// HPS/GPU-facing signal bundle for the instruction receiver.
// master = HPS write side plus graphics read side, slave = receiver.
interface hps_instr_receiver_if #(
   parameter int AW = 4
);
   logic [31:0] data_a;
   logic [31:0] data_b;
   logic        wrreg;
   logic        wrfull;
   logic        reset_pulsecounter;
   logic        screen;
   logic        frame_tick;
   logic        rd_en;
   logic [63:0] rd_data;
   logic        rd_valid;
   logic        empty;
   logic [AW:0] level;
   logic        overflow;

   modport master (
      output data_a, data_b, wrreg,
      output reset_pulsecounter, frame_tick, rd_en,
      input  wrfull, screen, rd_data, rd_valid,
      input  empty, level, overflow
   );

   modport slave (
      input  data_a, data_b, wrreg,
      input  reset_pulsecounter, frame_tick, rd_en,
      output wrfull, screen, rd_data, rd_valid,
      output empty, level, overflow
   );
endinterface

// File: rtl/hps_instr_receiver.sv
// HPS instruction FIFO with edge-detected push, registered pop
// and a saturating frame counter driving the screen flag.
module hps_instr_receiver #(
   parameter int DEPTH  = 16,
   parameter int AW     = 4,
   parameter int FRAMES = 1
) (
   input logic clk_clk,
   input logic reset_reset_n,
   hps_instr_receiver_if.slave bus
);
   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   level_q;
   logic [AW:0]   level_nx;
   logic          empty_q;
   logic          full_q;
   logic          ovf_q;
   logic          rd_valid_q;
   logic [63:0]   rd_data_q;
   logic          wrreg_q;
   logic          clr_q;
   logic [7:0]    cnt_q;
   logic [7:0]    cnt_nx;
   logic          screen_q;
   logic          push_req;
   logic          pop;
   logic          push;
   logic          clr;

   assign push_req = bus.wrreg & ~wrreg_q;
   assign clr      = bus.reset_pulsecounter & ~clr_q;
   assign pop      = bus.rd_en & ~empty_q;
   assign push     = push_req & (~full_q | pop);

   always_comb begin
      level_nx = level_q;
      unique case ({push, pop})
         2'b10:   level_nx = level_q + (AW+1)'(1);
         2'b01:   level_nx = level_q - (AW+1)'(1);
         default: level_nx = level_q;
      endcase
   end

   // clear has priority over a coincident tick
   always_comb begin
      cnt_nx = cnt_q;
      if (clr)
         cnt_nx = 8'd0;
      else if (bus.frame_tick && cnt_q != 8'hFF)
         cnt_nx = cnt_q + 8'd1;
   end

   always_ff @(posedge clk_clk) begin
      if (push)
         mem[wr_ptr] <= {bus.data_b, bus.data_a};
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         ovf_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         wrreg_q    <= 1'b0;
         clr_q      <= 1'b0;
         cnt_q      <= '0;
         screen_q   <= 1'b0;
      end else begin
         wrreg_q    <= bus.wrreg;
         clr_q      <= bus.reset_pulsecounter;
         rd_valid_q <= pop;
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr    <= rd_ptr + AW'(1);
            rd_data_q <= mem[rd_ptr];
         end
         if (push_req && full_q && !pop)
            ovf_q <= 1'b1;
         level_q  <= level_nx;
         empty_q  <= (level_nx == '0);
         full_q   <= (level_nx == (AW+1)'(DEPTH));
         cnt_q    <= cnt_nx;
         screen_q <= (cnt_nx >= 8'(FRAMES));
      end
   end

   assign bus.wrfull   = full_q;
   assign bus.empty    = empty_q;
   assign bus.level    = level_q;
   assign bus.overflow = ovf_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.screen   = screen_q;
endmodule
